// File: rtl/cmul_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential complex multiplier.
// slave is the multiplier's view; master is the source/consumer side.
interface cmul_seq_ctrl_if;
   logic              in_valid;
   logic              in_ready;
   logic signed [3:0] a_r;
   logic signed [3:0] a_i;
   logic signed [3:0] b_r;
   logic signed [3:0] b_i;
   logic              conj;
   logic              out_valid;
   logic              out_ready;
   logic signed [8:0] p_r;
   logic signed [8:0] p_i;

   modport slave (
      input  in_valid, a_r, a_i, b_r, b_i, conj, out_ready,
      output in_ready, out_valid, p_r, p_i
   );

   modport master (
      output in_valid, a_r, a_i, b_r, b_i, conj, out_ready,
      input  in_ready, out_valid, p_r, p_i
   );
endinterface

// File: rtl/cmul_seq_ctrl.sv
// Signed 4-bit complex (conjugate) multiplier that reuses one 4x4 real
// multiplier over four cycles, with valid/ready handshakes on both sides.
module cmul_seq_ctrl (
   input  logic                clk,
   input  logic                rst,
   cmul_seq_ctrl_if.slave      bus,
   output logic                busy,
   output logic [7:0]          done_cnt
);

   typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DONE} state_t;

   state_t            state;
   state_t            next_state;

   logic signed [3:0] a_r_q;
   logic signed [3:0] a_i_q;
   logic signed [3:0] b_r_q;
   logic signed [3:0] b_i_q;
   logic              conj_q;

   logic signed [8:0] acc_r;
   logic signed [8:0] acc_i;

   logic signed [7:0] mul_x;
   logic signed [7:0] mul_y;
   logic signed [7:0] prod;
   logic signed [8:0] prod_ext;

   logic              accept;
   logic              xfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) next_state = M0;
         end
         M0: next_state = M1;
         M1: next_state = M2;
         M2: next_state = M3;
         M3: next_state = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept = (state == IDLE) && bus.in_valid;
   assign xfer   = (state == DONE) && bus.out_ready;

   // Operand mux widens to 8 bits so the 8x8 product's low byte is the exact signed 4x4 product.
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (state)
         M0: begin
            mul_x = {{4{a_r_q[3]}}, a_r_q};
            mul_y = {{4{b_r_q[3]}}, b_r_q};
         end
         M1: begin
            mul_x = {{4{a_i_q[3]}}, a_i_q};
            mul_y = {{4{b_i_q[3]}}, b_i_q};
         end
         M2: begin
            mul_x = {{4{a_r_q[3]}}, a_r_q};
            mul_y = {{4{b_i_q[3]}}, b_i_q};
         end
         M3: begin
            mul_x = {{4{a_i_q[3]}}, a_i_q};
            mul_y = {{4{b_r_q[3]}}, b_r_q};
         end
         default: ;
      endcase
   end

   assign prod     = mul_x * mul_y;
   assign prod_ext = {prod[7], prod};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r_q    <= '0;
         a_i_q    <= '0;
         b_r_q    <= '0;
         b_i_q    <= '0;
         conj_q   <= 1'b0;
         acc_r    <= '0;
         acc_i    <= '0;
         done_cnt <= '0;
      end else begin
         if (accept) begin
            a_r_q  <= bus.a_r;
            a_i_q  <= bus.a_i;
            b_r_q  <= bus.b_r;
            b_i_q  <= bus.b_i;
            conj_q <= bus.conj;
         end
         case (state)
            M0: acc_r <= prod_ext;
            M1: acc_r <= conj_q ? acc_r + prod_ext : acc_r - prod_ext;
            M2: acc_i <= conj_q ? -prod_ext : prod_ext;
            M3: acc_i <= acc_i + prod_ext;
            default: ;
         endcase
         if (xfer) done_cnt <= done_cnt + 8'd1;
      end
   end

   assign bus.p_r = acc_r;
   assign bus.p_i = acc_i;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// Directed and randomized checks of cmul_seq_ctrl: latency, products,
// backpressure, asynchronous reset and done_cnt wrap.
module tb_cmul_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [7:0] done_cnt;

   cmul_seq_ctrl_if bus ();

   cmul_seq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc      = 0;
   int unsigned acc_cyc  = 0;
   int          exp_cnt  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic void model(input int ar, input int ai, input int br, input int bi,
                                 input int cj, output int pr, output int pi);
      if (cj == 0) begin
         pr = ar * br - ai * bi;
         pi = ar * bi + ai * br;
      end else begin
         pr = ar * br + ai * bi;
         pi = ai * br - ar * bi;
      end
   endfunction

   task automatic set_ops(input int ar, input int ai, input int br, input int bi, input int cj);
      bus.a_r  = 4'(ar);
      bus.a_i  = 4'(ai);
      bus.b_r  = 4'(br);
      bus.b_i  = 4'(bi);
      bus.conj = cj[0];
   endtask

   // Called at a negedge with in_valid high; returns at the negedge after the accept edge.
   task automatic wait_accept();
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      acc_cyc = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (!bus.out_valid) check("done_timeout", 0, 1);
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      check("done_cnt", int'(done_cnt), exp_cnt);
      check("in_ready_after_xfer", int'(bus.in_ready), 1);
   endtask

   task automatic run_directed(input string tag, input int ar, input int ai, input int br,
                               input int bi, input int cj, input int er, input int ei);
      int lat;
      set_ops(ar, ai, br, bi, cj);
      bus.in_valid = 1'b1;
      wait_accept();
      check({tag, "_in_ready_low"}, int'(bus.in_ready), 0);
      check({tag, "_busy"}, int'(busy), 1);
      wait_done(lat);
      check({tag, "_latency"}, lat, 4);
      check({tag, "_p_r"}, int'(bus.p_r), er);
      check({tag, "_p_i"}, int'(bus.p_i), ei);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ar, ai, br, bi, cj, er, ei;
      int unsigned prev_acc;
      int unsigned min_sp;
      bit          got;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      set_ops(0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_p_r", int'(bus.p_r), 0);
      check("rst_p_i", int'(bus.p_i), 0);
      check("rst_done_cnt", int'(done_cnt), 0);
      rst = 1'b0;
      @(negedge clk);

      run_directed("basic", 3, -2, -4, 5, 0, -2, 23);
      run_directed("conj", 3, -2, -4, 5, 1, -22, -7);
      run_directed("ext", -8, -8, -8, -8, 0, 0, 128);
      run_directed("ext_conj", -8, -8, -8, -8, 1, 128, 0);

      // Backpressure with a second request waiting
      set_ops(2, -1, 3, 1, 0);
      bus.in_valid = 1'b1;
      wait_accept();
      wait_done(lat);
      set_ops(1, 2, 3, 4, 0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", int'(bus.out_valid), 1);
         check("bp_p_r", int'(bus.p_r), 7);
         check("bp_p_i", int'(bus.p_i), -1);
         check("bp_in_ready", int'(bus.in_ready), 0);
      end
      drain();
      check("bp_busy_idle", int'(busy), 0);
      @(posedge clk);
      @(negedge clk);
      check("bp_next_accepted", int'(busy), 1);
      bus.in_valid = 1'b0;
      wait_done(lat);
      check("bp_next_latency", lat, 4);
      check("bp_next_p_r", int'(bus.p_r), -5);
      check("bp_next_p_i", int'(bus.p_i), 10);
      drain();

      // Asynchronous reset while in M2
      set_ops(3, -2, -4, 5, 0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_out_valid", int'(bus.out_valid), 0);
      check("arst_p_r", int'(bus.p_r), 0);
      check("arst_p_i", int'(bus.p_i), 0);
      check("arst_done_cnt", int'(done_cnt), 0);
      check("arst_in_ready", int'(bus.in_ready), 1);
      check("arst_busy", int'(busy), 0);
      #3 rst = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      run_directed("post_rst", 1, 2, 3, 4, 1, 11, 2);

      // Streaming: 256 operations with random consumer stalls
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt  = 0;
      min_sp   = 32'hFFFF_FFFF;
      prev_acc = 0;
      for (int k = 0; k < 256; k++) begin
         ar = int'($urandom_range(0, 15)) - 8;
         ai = int'($urandom_range(0, 15)) - 8;
         br = int'($urandom_range(0, 15)) - 8;
         bi = int'($urandom_range(0, 15)) - 8;
         cj = int'($urandom_range(0, 1));
         model(ar, ai, br, bi, cj, er, ei);
         set_ops(ar, ai, br, bi, cj);
         bus.in_valid = 1'b1;
         wait_accept();
         if (k > 0 && (acc_cyc - prev_acc) < min_sp) min_sp = acc_cyc - prev_acc;
         prev_acc = acc_cyc;
         got = 1'b0;
         for (int n = 0; n < 200 && !got; n++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
               check("stream_p_r", int'(bus.p_r), er);
               check("stream_p_i", int'(bus.p_i), ei);
               got = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
         end
         bus.out_ready = 1'b0;
         if (!got) check("stream_timeout", 0, 1);
         exp_cnt = (exp_cnt + 1) % 256;
         check("stream_done_cnt", int'(done_cnt), exp_cnt);
      end
      check("wrap_done_cnt", int'(done_cnt), 0);
      check("accept_spacing_ge6", int'(min_sp >= 6), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cmul_seq_ctrl.md
# cmul_seq_ctrl

Sequencing controller that computes a signed complex product (or conjugate product) from 4-bit signed components by time-multiplexing a single 4x4 signed real multiplier over four cycles, instead of four parallel multipliers. It sits beside the fully parallel complex multiplier as the area-optimised alternative. It is fed by an upstream operand source and drained by a downstream consumer over valid/ready handshakes on both sides.

## Interface
Parameters:
- none; all widths are fixed (4-bit signed operand components, 9-bit signed results).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a_r, a_i, b_r, b_i  in  4 each  signed two's-complement operand components.
- conj  in  1  captured with the operands; 1 selects p = a*conj(b), 0 selects p = a*b.
- out_valid  out  1  result p_r/p_i valid; held until it is accepted.
- out_ready  in  1  consumer accepts the result.
- p_r, p_i  out  9 each  signed real/imaginary result.
- busy  out  1  high in any state other than IDLE.
- done_cnt  out  8  count of completed output transfers; wraps 255->0.

## Operation
- FSM states: IDLE, M0, M1, M2, M3, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register a_r/a_i/b_r/b_i/conj and go to M0. Otherwise stay.
- One shared multiplier. Its operand muxes are driven by state. Its 8-bit signed product is sign-extended to 9 bits before any add or subtract.
- M0: acc_r <= a_r*b_r; go to M1.
- M1: acc_r <= acc_r - a_i*b_i if conj=0; acc_r <= acc_r + a_i*b_i if conj=1. Go to M2.
- M2: acc_i <= a_r*b_i if conj=0; acc_i <= -(a_r*b_i) if conj=1. Go to M3.
- M3: acc_i <= acc_i + a_i*b_r; go to DONE.
- DONE: out_valid=1. p_r/p_i are driven directly from acc_r/acc_i and stay stable. On out_valid&out_ready, increment done_cnt and go to IDLE.
- Arithmetic is exact; no saturation is needed:
  - conj=0: p_r range -120..120, p_i range -112..128.
  - conj=1: p_r range -112..128, p_i range -120..120.
- Inputs are ignored outside IDLE. in_valid while busy is not accepted and not lost: it must stay asserted per the handshake rule.
- Reset (asynchronous, any state, including mid-computation):
  - State goes to IDLE and the in-flight operation is discarded; no partial result appears.
  - out_valid=0, p_r=0, p_i=0, done_cnt=0, busy=0, in_ready=1.
  - Operand registers are cleared to 0.

## Timing
- Accept at rising edge E0. Computation completes at E4, and out_valid is high from E4 to acceptance. Latency is 4 cycles from accept to out_valid.
- Results are accepted at the first edge with out_valid&out_ready. in_ready rises in the cycle after that edge, and the next accept can occur at the following edge.
- Maximum throughput: one result per 6 cycles when out_ready is held high.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational input-to-output paths. in_ready does not depend on out_ready.
- Backpressure: with out_ready low, DONE holds indefinitely and p_r/p_i/out_valid stay unchanged.
- Upstream must hold operands and in_valid stable until accepted. The block does not rely on this beyond the accept edge.
- done_cnt updates on the same edge as the output transfer.

## Test plan
- Basic product: a=(3,-2), b=(-4,5), conj=0, out_ready=1.
  - in_ready drops the cycle after accept and out_valid rises 4 cycles after accept.
  - p_r=-2, p_i=23; done_cnt=1.
- Conjugate product: same operands, conj=1 -> p_r=-22, p_i=-7.
- Extremes: a=(-8,-8), b=(-8,-8), conj=0 -> p_r=0, p_i=128. Same operands with conj=1 -> p_r=128, p_i=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - p_r/p_i/out_valid remain stable and in_ready stays 0.
  - A new in_valid presented during this time is not accepted until 1 cycle after the output transfer.
- Reset mid-operation: assert rst asynchronously (not clock-aligned) in state M2.
  - out_valid=0, p_r=p_i=0, done_cnt=0, in_ready=1 immediately.
  - After release, a fresh operation returns correct results.
- Streaming and wrap: 256 back-to-back random operations with a random out_ready duty cycle, checked against a reference model.
  - Every result matches the model.
  - done_cnt wraps to 0 after the 256th transfer.
  - Spacing between accepts is at least 6 cycles.
